// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling compare points
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_type;

  localparam logic [4:0] BIT_SAMPLING     = 5'd15;
  localparam logic [4:0] HALFBIT_SAMPLING = 5'd7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both flops reset to
// RESET_VAL so an idle line does not look like activity coming out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/receiver.sv
// UART receiver, 16x oversampled, LSB-first, mid-bit sampling. Define
// RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module receiver
  import uart_pkg::*;
#(
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  tick,
  output logic [BYTE_WIDTH-1:0] data_out,
  output logic                  rx_done,
  output logic                  frame_error,
  output logic                  parity_error
);

  localparam int NB_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam logic [NB_W-1:0] LAST_BIT = NB_W'(BYTE_WIDTH - 1);

  logic rx_sync;

  state_type             state_q,       state_d;
  logic [4:0]            os_cnt_q,      os_cnt_d;
  logic [NB_W-1:0]       nbits_q,       nbits_d;
  logic [BYTE_WIDTH-1:0] shreg_q,       shreg_d;
  logic [BYTE_WIDTH-1:0] data_out_q,    data_out_d;
  logic                  rx_done_q,     rx_done_d;
  logic                  frame_error_q, frame_error_d;
`ifdef RX_PARITY_EN
  logic                  parity_bit_q,   parity_bit_d;
  logic                  parity_error_q, parity_error_d;
`endif

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_sync)
  );

  always_comb begin
    state_d       = state_q;
    os_cnt_d      = os_cnt_q;
    nbits_d       = nbits_q;
    shreg_d       = shreg_q;
    data_out_d    = data_out_q;
    rx_done_d     = 1'b0;
    frame_error_d = frame_error_q;
`ifdef RX_PARITY_EN
    parity_bit_d   = parity_bit_q;
    parity_error_d = parity_error_q;
`endif

    case (state_q)
      IDLE: begin
        nbits_d = '0;
        if (!rx_sync) begin
          os_cnt_d = '0;
          state_d  = START;
        end
      end

      START: begin
        if (tick) begin
          if (os_cnt_q == HALFBIT_SAMPLING) begin
            // A start bit that is gone by mid-bit was a glitch; drop it silently.
            if (!rx_sync) begin
              os_cnt_d = '0;
              state_d  = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + 5'd1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (os_cnt_q == BIT_SAMPLING) begin
            shreg_d  = {rx_sync, shreg_q[BYTE_WIDTH-1:1]};
            os_cnt_d = '0;
            if (nbits_q == LAST_BIT) begin
`ifdef RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              nbits_d = nbits_q + 1'b1;
            end
          end else begin
            os_cnt_d = os_cnt_q + 5'd1;
          end
        end
      end

`ifdef RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (os_cnt_q == BIT_SAMPLING) begin
            parity_bit_d = rx_sync;
            os_cnt_d     = '0;
            state_d      = STOP;
          end else begin
            os_cnt_d = os_cnt_q + 5'd1;
          end
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (os_cnt_q == BIT_SAMPLING) begin
            // The byte is always delivered; errors only ride alongside it.
            data_out_d    = shreg_q;
            rx_done_d     = 1'b1;
            frame_error_d = ~rx_sync;
`ifdef RX_PARITY_EN
            parity_error_d = ^{shreg_q, parity_bit_q};
`endif
            state_d = IDLE;
          end else begin
            os_cnt_d = os_cnt_q + 5'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      os_cnt_q      <= '0;
      nbits_q       <= '0;
      shreg_q       <= '0;
      data_out_q    <= '0;
      rx_done_q     <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef RX_PARITY_EN
      parity_bit_q   <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      os_cnt_q      <= os_cnt_d;
      nbits_q       <= nbits_d;
      shreg_q       <= shreg_d;
      data_out_q    <= data_out_d;
      rx_done_q     <= rx_done_d;
      frame_error_q <= frame_error_d;
`ifdef RX_PARITY_EN
      parity_bit_q   <= parity_bit_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign rx_done     = rx_done_q;
  assign frame_error = frame_error_q;
`ifdef RX_PARITY_EN
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: directed frames plus random frames, checked
// against a frame-level model of what each transmitted frame should produce.
module tb_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_error;
  logic       parity_error;

  int chk_cnt = 0;
  int pass_cnt = 0;

`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  receiver #(.BYTE_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .tick        (tick),
    .data_out    (data_out),
    .rx_done     (rx_done),
    .frame_error (frame_error),
    .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  // Baud tick: one clock high out of every four.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // Capture every rx_done pulse and flag any pulse longer than one clock.
  logic [7:0] obs_data [0:255];
  logic       obs_ferr [0:255];
  logic       obs_perr [0:255];
  int         n_obs = 0;
  logic       prev_done = 1'b0;
  logic       long_pulse = 1'b0;

  always @(negedge clk) begin
    if (rx_done === 1'b1 && n_obs < 256) begin
      obs_data[n_obs] = data_out;
      obs_ferr[n_obs] = frame_error;
      obs_perr[n_obs] = parity_error;
      n_obs = n_obs + 1;
    end
    if (rx_done === 1'b1 && prev_done === 1'b1) long_pulse = 1'b1;
    prev_done = rx_done;
  end

  int         rd = 0;
  logic [7:0] last_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
    @(negedge clk);
  endtask

  // Drive one frame; a bad stop is low through its mid-bit sample then released.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_ok,
                            input int gap_ticks);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    if (PAR_EN) begin
      rx = pbit;
      wait_ticks(16);
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_ticks(16);
    end else begin
      rx = 1'b0;
      wait_ticks(12);
      rx = 1'b1;
      wait_ticks(20);
    end
    if (gap_ticks > 0) wait_ticks(gap_ticks);
  endtask

  // Model: each sent frame yields exactly one byte with the errors its bits imply.
  task automatic frame_and_check(input string tag, input logic [7:0] d, input logic pbit,
                                 input logic stop_ok, input int gap_ticks);
    logic exp_ferr;
    logic exp_perr;
    int   t;
    exp_ferr = ~stop_ok;
    exp_perr = PAR_EN ? (^{d, pbit}) : 1'b0;
    send_frame(d, pbit, stop_ok, gap_ticks);
    t = 0;
    while (n_obs <= rd && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, (n_obs > rd), 1);
    if (n_obs > rd) begin
      check({tag, "_data"}, obs_data[rd], d);
      check({tag, "_ferr"}, obs_ferr[rd], exp_ferr);
      check({tag, "_perr"}, obs_perr[rd], exp_perr);
      $display("frame %s: sent=0x%02h pbit=%0b stop_ok=%0b got=0x%02h ferr=%0b perr=%0b",
               tag, d, pbit, stop_ok, obs_data[rd], obs_ferr[rd], obs_perr[rd]);
      rd++;
    end else begin
      $display("frame %s: sent=0x%02h no rx_done seen", tag, d);
    end
    check({tag, "_held"}, data_out, d);
    last_data = d;
  endtask

  initial begin
    logic [7:0] rd_byte;
    logic       rp;
    logic       rs;
    int         rg;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_data", data_out, 8'h00);
    check("reset_done", rx_done, 1'b0);
    check("reset_ferr", frame_error, 1'b0);
    check("reset_perr", parity_error, 1'b0);
    wait_ticks(8);

    frame_and_check("a5", 8'hA5, 1'b0, 1'b1, 8);

    // Glitch: start bit gone before mid-bit.
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(40);
    check("glitch_no_done", n_obs, rd);
    check("glitch_data", data_out, last_data);
    $display("glitch: 4-tick low pulse, rx_done count=%0d", n_obs);

    frame_and_check("3c_badstop", 8'h3C, 1'b0, 1'b0, 8);
    check("3c_ferr_held", frame_error, 1'b1);
    frame_and_check("11_clean", 8'h11, 1'b1, 1'b1, 8);
    check("11_ferr_cleared", frame_error, 1'b0);

    // Abort a frame with reset after three data bits.
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1; wait_ticks(16);
    rx = 1'b0; wait_ticks(16);
    rx = 1'b1; wait_ticks(16);
    rx = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(20);
    check("midrst_data", data_out, 8'h00);
    check("midrst_done", rx_done, 1'b0);
    check("midrst_ferr", frame_error, 1'b0);
    check("midrst_perr", parity_error, 1'b0);
    check("midrst_no_done", n_obs, rd);
    $display("reset mid-frame: data_out=0x%02h", data_out);
    frame_and_check("5a", 8'h5A, 1'b0, 1'b1, 8);

    frame_and_check("b2b_00", 8'h00, 1'b0, 1'b1, 0);
    frame_and_check("b2b_ff", 8'hFF, 1'b0, 1'b1, 8);

    if (PAR_EN) begin
      frame_and_check("par07_p1", 8'h07, 1'b1, 1'b1, 8);
      frame_and_check("par07_p0", 8'h07, 1'b0, 1'b1, 8);
    end

    for (int k = 0; k < 16; k++) begin
      rd_byte = 8'($urandom_range(0, 255));
      rp      = 1'($urandom_range(0, 1));
      rs      = ($urandom_range(0, 4) != 0);
      rg      = $urandom_range(0, 20);
      frame_and_check($sformatf("rnd%0d", k), rd_byte, rp, rs, rg);
    end

    wait_ticks(40);
    check("no_extra_done", n_obs, rd);
    check("pulse_width_1clk", long_pulse, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/receiver.md
# receiver

UART receive path: recovers bytes from the serial `rx` line using the 16× oversampling `tick` from the shared baud rate generator and the same 8N1, LSB-first framing the transmitter drives. It synchronises the asynchronous line, validates the start bit at mid-bit, samples every data bit at mid-bit, checks the stop bit, and presents each byte with a one-cycle `rx_done` strobe. It sits opposite the transmitter, feeding the downstream command/byte-handling logic.

## Interface
- `BYTE_WIDTH`, default 8: number of data bits per frame.
- `clk`  input  1: single system clock, all logic on rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `rx`  input  1: asynchronous serial input; idle level is 1.
- `tick`  input  1: one-cycle pulse from the baud generator, 16 per bit period.
- `data_out`  output  BYTE_WIDTH: last received byte, held until the next `rx_done`.
- `rx_done`  output  1: one-cycle pulse when a frame completes.
- `frame_error`  output  1: stop bit sampled as 0; updated with each `rx_done` and held until the next one.
- `parity_error`  output  1: parity mismatch; updated with each `rx_done`. Tied to 0 when parity is compiled out.

## Operation
- `rx` passes through a two-flop synchroniser, giving `rx_sync`. Both flops reset to 1.
- Counters:
  - `os_cnt` (5 bits) counts `tick`s only.
  - `nbits` counts received data bits.
- Shift register `shreg` loads LSB-first: `shreg <= {rx_sync, shreg[BYTE_WIDTH-1:1]}`.
- State machine states:
  - IDLE: `nbits=0`. On `rx_sync==0`, set `os_cnt=0` and go to START. Ticks in IDLE are ignored.
  - START: on `tick` with `os_cnt==7` (HALFBIT_SAMPLING):
    - If `rx_sync==0`, set `os_cnt=0` and go to DATA.
    - Otherwise the start bit was a glitch: go to IDLE with no outputs changed.
    - Any other `tick` increments `os_cnt`.
  - DATA: on `tick` with `os_cnt==15` (BIT_SAMPLING), shift in `rx_sync` and set `os_cnt=0`.
    - If `nbits==BYTE_WIDTH-1`, go to STOP (or PARITY when enabled).
    - Otherwise increment `nbits`.
    - Any other `tick` increments `os_cnt`.
  - PARITY (only with the macro): on `tick` with `os_cnt==15`, capture the parity bit, set `os_cnt=0` and go to STOP.
  - STOP: on `tick` with `os_cnt==15`, perform the frame-completion register updates below and go to IDLE.
- Frame-completion register updates (all in the same cycle):
  - `data_out <= shreg`.
  - `rx_done <= 1`.
  - `frame_error <= ~rx_sync`.
  - `parity_error` updated (parity builds only).
- `rx_done` is asserted even when an error is flagged. Errors never suppress the byte.

## Timing
- Reset values: `data_out=0`, `rx_done=0`, `frame_error=0`, `parity_error=0`, state IDLE, `os_cnt=0`, `nbits=0`, `shreg=0`.
- Input latency: a falling edge on `rx` reaches `rx_sync` 2 clocks later.
- Output latency: `rx_done` rises on the clock edge that follows the cycle containing the stop-bit sampling `tick`. It is high for exactly 1 clock.
- Sampling points: the start bit is checked 8 ticks after detection; every later bit is sampled 16 ticks after the previous sample, which is nominal mid-bit.
- Break (line held low): the stop bit samples 0, so `frame_error=1`. The block returns to IDLE, sees `rx_sync==0` and re-enters START immediately. This is the required behaviour.
- Back-to-back frames: a start bit directly after the stop sample is accepted with no idle gap required.
- `rst` mid-frame: the next edge returns everything to reset values, and the partial byte is discarded. `rst` has priority over `tick`.
- `os_cnt` never exceeds 15. The comparisons use literal 7 and 15, not wrap-around.

## Configuration
- `RX_PARITY_EN` defined:
  - The PARITY state is inserted between DATA and STOP, so a frame is 11 bits.
  - Parity is even: `parity_error <= ^{shreg, parity_bit}` at frame completion.
- Undefined:
  - There is no PARITY state, and frames are 8N1.
  - `parity_error` is a constant 0.
  - The port list is identical in both builds.

## Structure
- Shared package `uart_pkg` holds:
  - the `state_type` enum (IDLE, START, DATA, PARITY, STOP);
  - `BIT_SAMPLING=15` and `HALFBIT_SAMPLING=7`.
- The transmitter uses the same package.
- One sub-module, `sync_2ff` (parameterised reset value), provides the `rx` synchroniser.

## Test plan
- Send 0xA5 at 16 ticks/bit, valid stop bit → `data_out=0xA5`, single 1-clock `rx_done`, `frame_error=0`.
- Pulse `rx` low for 4 ticks, then high → no `rx_done`, FSM back in IDLE, `data_out` unchanged.
- Send 0x3C with stop bit 0 → `rx_done` pulses, `data_out=0x3C`, `frame_error=1`. The next clean frame 0x11 clears `frame_error`.
- Assert `rst` for 1 clock after 3 data bits, then send 0x5A → all outputs 0 after reset, then `data_out=0x5A` with exactly one `rx_done`.
- Send 0x00 then 0xFF with no idle gap → two `rx_done` pulses, values 0x00 then 0xFF, no errors.
- With `RX_PARITY_EN`, send 0x07 → parity bit 1 gives `parity_error=0`; parity bit 0 gives `parity_error=1`.
